// File: rtl/shiftx_stream_unpacker.sv
// ============================================================================
// Module  : shiftx_stream_unpacker
// Brief   : Two-word LSB-first window feeding a downstream $shiftx (A/B)
//           extraction cell with consecutive FIELD_WIDTH-bit fields.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module shiftx_stream_unpacker #(
    parameter int IN_WIDTH    = 8,
    parameter int FIELD_WIDTH = 3,
    parameter int OFF_WIDTH   = $clog2(2*IN_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [IN_WIDTH-1:0]      in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [2*IN_WIDTH-1:0]    out_a,
    output logic [OFF_WIDTH-1:0]     out_b,
    output logic [FIELD_WIDTH-1:0]   out_field,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int                 c_BUF_W = 2*IN_WIDTH;
    localparam int                 c_CNT_W = OFF_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_WORD  = c_CNT_W'(IN_WIDTH);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(c_BUF_W);
    localparam logic [c_CNT_W-1:0] c_FIELD = c_CNT_W'(FIELD_WIDTH);

    logic [c_BUF_W-1:0]   r_buf;
    logic [c_CNT_W-1:0]   r_wr_cnt;
    logic [OFF_WIDTH-1:0] r_rd_off;

    logic [c_BUF_W-1:0]   w_buf_drop;
    logic [c_BUF_W-1:0]   w_buf_nxt;
    logic [c_CNT_W-1:0]   w_wr_drop;
    logic [c_CNT_W-1:0]   w_wr_nxt;
    logic [c_CNT_W-1:0]   w_rd_adv;
    logic [OFF_WIDTH-1:0] w_rd_nxt;
    logic [c_CNT_W-1:0]   w_avail;
    logic                 w_fire_in;
    logic                 w_fire_out;
    logic                 w_drop;

    // rd_off never exceeds wr_cnt, so this difference cannot wrap.
    assign w_avail    = r_wr_cnt - {1'b0, r_rd_off};
    assign in_ready   = !rst && !flush && (r_wr_cnt != c_FULL);
    assign out_valid  = !rst && !flush && (w_avail >= c_FIELD);
    assign out_a      = r_buf;
    assign out_b      = r_rd_off;
    assign out_field  = r_buf[r_rd_off +: FIELD_WIDTH];

    assign w_fire_in  = in_valid && in_ready;
    assign w_fire_out = out_valid && out_ready;

    always_comb begin
        w_rd_adv   = {1'b0, r_rd_off} + (w_fire_out ? c_FIELD : '0);
        w_drop     = (w_rd_adv >= c_WORD);
        w_buf_drop = w_drop ? (r_buf >> IN_WIDTH) : r_buf;
        w_wr_drop  = w_drop ? (r_wr_cnt - c_WORD) : r_wr_cnt;
        w_rd_nxt   = OFF_WIDTH'(w_drop ? (w_rd_adv - c_WORD) : w_rd_adv);
        w_buf_nxt  = w_buf_drop;
        w_wr_nxt   = w_wr_drop;
        // A write only happens when the pre-drop buffer was not full, so the
        // post-drop fill level is either empty or exactly one word.
        if (w_fire_in) begin
            if (w_wr_drop == '0) begin
                w_buf_nxt[IN_WIDTH-1:0] = in_data;
            end else begin
                w_buf_nxt[c_BUF_W-1:IN_WIDTH] = in_data;
            end
            w_wr_nxt = w_wr_drop + c_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_buf    <= '0;
            r_wr_cnt <= '0;
            r_rd_off <= '0;
        end else begin
            r_buf    <= w_buf_nxt;
            r_wr_cnt <= w_wr_nxt;
            r_rd_off <= w_rd_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shiftx_stream_unpacker.sv
// ============================================================================
// Module  : tb_shiftx_stream_unpacker
// Brief   : Self-checking bench; golden model is the accepted LSB-first
//           bitstream plus a count of consumed bits.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shiftx_stream_unpacker;

    localparam int c_N   = 8;
    localparam int c_F   = 3;
    localparam int c_OFF = $clog2(2*c_N);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [c_N-1:0]       in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*c_N-1:0]     out_a;
    logic [c_OFF-1:0]     out_b;
    logic [c_F-1:0]       out_field;
    logic                 out_valid;
    logic                 out_ready;

    shiftx_stream_unpacker #(.IN_WIDTH(c_N), .FIELD_WIDTH(c_F)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_field (out_field),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Golden model: every accepted bit in arrival order, and bits consumed.
    bit stream[$];
    int consumed = 0;
    int fields_done = 0;

    logic [2*c_N-1:0] s_a;
    logic [c_OFF-1:0] s_b;
    logic [c_F-1:0]   s_field;
    logic             s_valid;
    logic             s_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bit_at(input int idx);
        return (idx < stream.size()) ? stream[idx] : 1'b0;
    endfunction

    task automatic cyc(input logic r, input logic fl, input logic iv,
                       input logic [c_N-1:0] d, input logic ordy);
        int               held;
        int               base;
        logic             e_in_ready;
        logic             e_out_valid;
        logic [2*c_N-1:0] e_a;
        logic [c_F-1:0]   e_field;
        bit               f_in;
        bit               f_out;
        @(negedge clk);
        rst = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        held        = stream.size() / c_N - consumed / c_N;
        base        = (consumed / c_N) * c_N;
        e_in_ready  = !r && !fl && (held < 2);
        e_out_valid = !r && !fl && (stream.size() - consumed >= c_F);
        for (int i = 0; i < 2*c_N; i++) e_a[i] = bit_at(base + i);
        for (int i = 0; i < c_F; i++) e_field[i] = bit_at(consumed + i);
        check_eq("in_ready",  32'(in_ready),  32'(e_in_ready));
        check_eq("out_valid", 32'(out_valid), 32'(e_out_valid));
        check_eq("out_a",     32'(out_a),     32'(e_a));
        check_eq("out_b",     32'(out_b),     32'(consumed % c_N));
        check_eq("out_field", 32'(out_field), 32'(e_field));
        check_eq("b_range",   32'(int'(out_b) < c_N), 32'd1);
        s_a = out_a; s_b = out_b; s_field = out_field;
        s_valid = out_valid; s_ready = in_ready;
        f_in  = e_in_ready && iv;
        f_out = e_out_valid && ordy;
        @(posedge clk);
        if (r || fl) begin
            stream.delete();
            consumed = 0;
        end else begin
            if (f_out) begin
                consumed += c_F;
                fields_done++;
            end
            if (f_in) for (int i = 0; i < c_N; i++) stream.push_back(d[i]);
        end
    endtask

    initial begin
        int cycles;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        @(posedge clk);

        // Reset held with in_valid asserted
        cyc(1, 0, 1, 8'hA5, 1);
        cyc(1, 0, 1, 8'hA5, 1);
        check_eq("rst_a", 32'(s_a), 32'h0);
        cyc(0, 0, 0, 8'h00, 1);
        check_eq("rel_in_ready",  32'(s_ready), 32'd1);
        check_eq("rel_out_valid", 32'(s_valid), 32'd0);

        // Basic extraction and straddle
        cyc(0, 0, 1, 8'hB5, 1);
        cyc(0, 0, 0, 8'h00, 1);
        check_eq("f0", 32'(s_field), 32'b101);
        check_eq("b0", 32'(s_b), 32'd0);
        cyc(0, 0, 0, 8'h00, 1);
        check_eq("f1", 32'(s_field), 32'b110);
        check_eq("b1", 32'(s_b), 32'd3);
        cyc(0, 0, 1, 8'h01, 1);
        check_eq("b2", 32'(s_b), 32'd6);
        check_eq("v2", 32'(s_valid), 32'd0);
        cyc(0, 0, 0, 8'h00, 1);
        check_eq("f_straddle", 32'(s_field), 32'b110);
        cyc(0, 0, 0, 8'h00, 1);
        check_eq("a_drop", 32'(s_a), 32'h0001);
        check_eq("b_drop", 32'(s_b), 32'd1);
        check_eq("f_drop", 32'(s_field), 32'b000);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 1, 1, 8'h33, 1);

        // Full buffer with backpressure
        cyc(0, 0, 1, 8'hFF, 0);
        cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 0, 1, 8'hAA, 0);
        check_eq("full_ready", 32'(s_ready), 32'd0);
        check_eq("full_a", 32'(s_a), 32'h00FF);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'hAA, 1);

        // Flush mid-stream with both handshakes offered
        cyc(0, 1, 1, 8'h5A, 1);
        check_eq("fl_ready", 32'(s_ready), 32'd0);
        check_eq("fl_valid", 32'(s_valid), 32'd0);
        cyc(0, 0, 0, 8'h00, 0);
        check_eq("fl_a", 32'(s_a), 32'h0);
        check_eq("fl_b", 32'(s_b), 32'd0);

        // Randomized stream against the golden bitstream
        fields_done = 0;
        cycles = 0;
        while (fields_done < 1000 && cycles < 20000) begin
            cyc(0, 0, ($urandom_range(0, 99) < 55), c_N'($urandom),
                ($urandom_range(0, 99) < 75));
            cycles++;
        end
        check_eq("rand_fields_done", 32'(fields_done >= 1000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
